// File: rtl/mem_port_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter_pkg: shared state encodings and requester IDs        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    // A disabled timeout still needs a legal, non-zero counter width.
    function automatic int wait_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter_if: requester and memory-side signals of the arbiter |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic                  err0;
    logic                  err1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  stall0;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // The arbiter is the bus master of the memory port.
    modport master (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_ready, mem_rdata,
        output ack0, ack1, err0, err1, rdata, stall0,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_ready, mem_rdata,
        input  ack0, ack1, err0, err1, rdata, stall0,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// +----------------------------------------------------------------------+
// | rr_arbiter2: combinational two-way round-robin grant selection        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       enable_i,
    output logic       grant_id_o,
    output logic       valid_o
);

    always_comb begin
        valid_o    = enable_i & (|req_i);
        grant_id_o = REQ_CPU;
        if (req_i == 2'b11) begin
            grant_id_o = ~last_i;
        end else if (req_i[1]) begin
            grant_id_o = REQ_AUX;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter: serialises two requesters onto one memory port     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.master bus
);

    localparam int c_WAIT_W = wait_width(TIMEOUT);

    state_t                state_q;
    logic                  last_q;
    logic                  gnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_req_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  err0_q;
    logic                  err1_q;
    logic [c_WAIT_W-1:0]   wait_q;

    logic                  w_grant_id;
    logic                  w_grant_valid;
    logic                  w_timeout;

    rr_arbiter2 u_rr_arbiter2 (
        .req_i      ({bus.req1, bus.req0}),
        .last_i     (last_q),
        .enable_i   (state_q == IDLE),
        .grant_id_o (w_grant_id),
        .valid_o    (w_grant_valid)
    );

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (wait_q == c_WAIT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= REQ_AUX;
            gnt_q     <= REQ_CPU;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            wait_q    <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_grant_valid) begin
                        gnt_q     <= w_grant_id;
                        last_q    <= w_grant_id;
                        we_q      <= (w_grant_id == REQ_AUX) ? bus.we1    : bus.we0;
                        addr_q    <= (w_grant_id == REQ_AUX) ? bus.addr1  : bus.addr0;
                        wdata_q   <= (w_grant_id == REQ_AUX) ? bus.wdata1 : bus.wdata0;
                        mem_req_q <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A ready on the last allowed cycle still counts as success.
                    if (bus.mem_ready) begin
                        if (!we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        mem_req_q <= 1'b0;
                        ack0_q    <= (gnt_q == REQ_CPU);
                        ack1_q    <= (gnt_q == REQ_AUX);
                        state_q   <= RESP;
                    end else if (w_timeout) begin
                        rdata_q   <= '0;
                        mem_req_q <= 1'b0;
                        ack0_q    <= (gnt_q == REQ_CPU);
                        ack1_q    <= (gnt_q == REQ_AUX);
                        err0_q    <= (gnt_q == REQ_CPU);
                        err1_q    <= (gnt_q == REQ_AUX);
                        state_q   <= RESP;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err0      = err0_q;
    assign bus.err1      = err1_q;
    assign bus.rdata     = rdata_q;
    assign bus.stall0    = bus.req0 & ~ack0_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed self-checking bench, TIMEOUT=4          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs for a cycle are applied just after its opening edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        bus.we0  = 1'b0;  bus.we1  = 1'b0;
        bus.addr0 = '0;   bus.addr1 = '0;
        bus.wdata0 = '0;  bus.wdata1 = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        step();
        step();
        @(negedge clk);
        chk("rst_mem_req",  32'(bus.mem_req),  32'd0);
        chk("rst_mem_we",   32'(bus.mem_we),   32'd0);
        chk("rst_mem_addr", bus.mem_addr,      32'd0);
        chk("rst_mem_wdat", bus.mem_wdata,     32'd0);
        chk("rst_ack0",     32'(bus.ack0),     32'd0);
        chk("rst_ack1",     32'(bus.ack1),     32'd0);
        chk("rst_err0",     32'(bus.err0),     32'd0);
        chk("rst_err1",     32'(bus.err1),     32'd0);
        chk("rst_rdata",    bus.rdata,         32'd0);
        chk("rst_stall0",   32'(bus.stall0),   32'd0);

        // Zero-wait read from requester 0
        step();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.addr0 = 32'h10;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_c0_stall0", 32'(bus.stall0),  32'd1);
        chk("rd_c0_mreq",   32'(bus.mem_req), 32'd0);
        step();
        @(negedge clk);
        chk("rd_c1_mreq",   32'(bus.mem_req), 32'd1);
        chk("rd_c1_addr",   bus.mem_addr,     32'h10);
        chk("rd_c1_we",     32'(bus.mem_we),  32'd0);
        chk("rd_c1_stall0", 32'(bus.stall0),  32'd1);
        chk("rd_c1_ack0",   32'(bus.ack0),    32'd0);
        step();
        @(negedge clk);
        chk("rd_c2_ack0",   32'(bus.ack0),    32'd1);
        chk("rd_c2_err0",   32'(bus.err0),    32'd0);
        chk("rd_c2_ack1",   32'(bus.ack1),    32'd0);
        chk("rd_c2_rdata",  bus.rdata,        32'hDEADBEEF);
        chk("rd_c2_stall0", 32'(bus.stall0),  32'd0);
        chk("rd_c2_mreq",   32'(bus.mem_req), 32'd0);

        // Write from requester 1 with three wait cycles
        step();
        bus.req0 = 1'b0; bus.mem_ready = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h40; bus.wdata1 = 32'h1234;
        @(negedge clk);
        chk("wr_c0_ack0", 32'(bus.ack0), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) bus.mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("wr_c%0d_mreq", k),  32'(bus.mem_req), 32'd1);
            chk($sformatf("wr_c%0d_we", k),    32'(bus.mem_we),  32'd1);
            chk($sformatf("wr_c%0d_addr", k),  bus.mem_addr,     32'h40);
            chk($sformatf("wr_c%0d_wdata", k), bus.mem_wdata,    32'h1234);
            chk($sformatf("wr_c%0d_ack1", k),  32'(bus.ack1),    32'd0);
        end
        step();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("wr_c5_ack1",  32'(bus.ack1), 32'd1);
        chk("wr_c5_err1",  32'(bus.err1), 32'd0);
        chk("wr_c5_ack0",  32'(bus.ack0), 32'd0);
        chk("wr_c5_rdata", bus.rdata,     32'hDEADBEEF);

        // Both requesters held high; requester 1 was served last so 0 goes first
        step();
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 32'h100; bus.addr1 = 32'h200;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            @(negedge clk);
            chk($sformatf("rr_k%0d_ack0", k), 32'(bus.ack0),    ((k % 6) == 2) ? 32'd1 : 32'd0);
            chk($sformatf("rr_k%0d_ack1", k), 32'(bus.ack1),    ((k % 6) == 5) ? 32'd1 : 32'd0);
            chk($sformatf("rr_k%0d_mreq", k), 32'(bus.mem_req), ((k % 3) == 1) ? 32'd1 : 32'd0);
            chk($sformatf("rr_k%0d_both", k), 32'(bus.ack0 & bus.ack1), 32'd0);
            if ((k % 3) == 1) begin
                chk($sformatf("rr_k%0d_addr", k), bus.mem_addr,
                    ((k % 6) == 1) ? 32'h100 : 32'h200);
            end
        end

        // Timeout on requester 0 with memory never ready
        step();
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.addr0 = 32'h80; bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("to_c0_mreq", 32'(bus.mem_req), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("to_c%0d_mreq", k), 32'(bus.mem_req), 32'd1);
            chk($sformatf("to_c%0d_ack0", k), 32'(bus.ack0),    32'd0);
        end
        step();
        @(negedge clk);
        chk("to_c5_ack0",  32'(bus.ack0),    32'd1);
        chk("to_c5_err0",  32'(bus.err0),    32'd1);
        chk("to_c5_rdata", bus.rdata,        32'd0);
        chk("to_c5_mreq",  32'(bus.mem_req), 32'd0);

        // Normal access after the timeout clears the error
        step();
        bus.addr0 = 32'h84; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA55AA;
        step();
        @(negedge clk);
        chk("nt_c1_addr", bus.mem_addr, 32'h84);
        step();
        @(negedge clk);
        chk("nt_c2_ack0",  32'(bus.ack0), 32'd1);
        chk("nt_c2_err0",  32'(bus.err0), 32'd0);
        chk("nt_c2_rdata", bus.rdata,     32'h55AA55AA);

        // Reset pulsed during the second ACCESS cycle
        step();
        bus.addr0 = 32'h90; bus.mem_ready = 1'b0;
        step();
        @(negedge clk);
        chk("rs_c1_mreq", 32'(bus.mem_req), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; bus.req0 = 1'b0;
        @(negedge clk);
        chk("rs_c3_mreq",  32'(bus.mem_req), 32'd0);
        chk("rs_c3_ack0",  32'(bus.ack0),    32'd0);
        chk("rs_c3_addr",  bus.mem_addr,     32'd0);
        chk("rs_c3_rdata", bus.rdata,        32'd0);
        step();
        bus.req1 = 1'b1; bus.addr1 = 32'h44; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13579BDF;
        @(negedge clk);
        chk("rs_c4_ack0", 32'(bus.ack0),    32'd0);
        chk("rs_c4_mreq", 32'(bus.mem_req), 32'd0);
        step();
        @(negedge clk);
        chk("rs_c5_mreq", 32'(bus.mem_req), 32'd1);
        chk("rs_c5_addr", bus.mem_addr,     32'h44);
        step();
        @(negedge clk);
        chk("rs_c6_ack1",  32'(bus.ack1), 32'd1);
        chk("rs_c6_ack0",  32'(bus.ack0), 32'd0);
        chk("rs_c6_err1",  32'(bus.err1), 32'd0);
        chk("rs_c6_rdata", bus.rdata,     32'h13579BDF);
        step();
        bus.req1 = 1'b0; bus.mem_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the multi-cycle CPU. Requester 0 is the CPU memory interface: fetch and lw/sw in the IR, MemoryAccessRead and MemoryAccessWrite steps. Requester 1 is a secondary master, such as a program loader or debug port. The block serialises accesses, drives a variable-latency memory handshake, and returns data, an acknowledge and an error flag to the winning requester. It sits between the datapath memory mux and the memory model.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 16, max cycles waiting for mem_ready; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; held until the matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_WIDTH  byte address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with ack; 1 = timed out
- rdata  out  DATA_WIDTH  read data; valid with ack0 or ack1
- stall0  out  1  req0 & ~ack0, combinational; drives CPU hold
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory has completed the access this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready=1

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick a winner, latch its we/addr/wdata into command registers and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration is round-robin with a last-served pointer.
  - If only one requester asserts req, it wins.
  - If both assert req, the requester not served last wins.
  - The pointer updates when a grant is issued.
- ACCESS:
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the command registers and are stable throughout.
  - On an edge with mem_ready=1: latch mem_rdata into rdata (reads only), clear the error, go to RESP.
  - Timeout (TIMEOUT>0): if the wait counter reaches TIMEOUT-1 with mem_ready=0, set the error, load rdata=0 and go to RESP.
- RESP:
  - ack and err of the granted requester are asserted for this single cycle; then go to IDLE.
  - A new request is not considered in RESP. This guarantees the served requester sees ack before re-arbitration.
- rdata holds its value until the next completed read or reset.
- Writes leave rdata unchanged.
- If a requester drops req during ACCESS, the access still completes and ack still pulses. Requesters must not do this.
- Wait counter:
  - Width is clog2(TIMEOUT+1).
  - Clears on entry to ACCESS and increments each ACCESS cycle.
  - Does not wrap: the timeout exits before overflow.

## Timing
- Reset values: state=IDLE, pointer favours req0 first, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ack0=ack1=0, err0=err1=0, rdata=0, wait counter=0. stall0 follows req0.
- Minimum latency: req at cycle 0 → mem_req at cycle 1 → ack at cycle 2, given mem_ready=1 in cycle 1.
- Each extra wait cycle of mem_ready adds one cycle.
- Back-to-back: at most one access per 3 cycles.
- With both requesters continuously requesting, grants alternate 0,1,0,1.
- rst asserted mid-ACCESS or mid-RESP:
  - Next edge returns to IDLE with all outputs at their reset values.
  - The pending ack is lost.
  - mem_req drops after that same edge.
- mem_ready outside ACCESS is ignored.

## Structure
- Shared header holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - requester IDs REQ_CPU=1'b0, REQ_AUX=1'b1
- Sub-module rr_arbiter2 (the natural split):
  - inputs req[1:0], last, enable
  - outputs grant_id and valid, combinational
  - the pointer register stays in the parent

## Test plan
- Single read, zero-wait: req0=1, addr0=0x10, mem_ready high in first ACCESS cycle, mem_rdata=0xDEADBEEF → ack0 at cycle 2, rdata=0xDEADBEEF, err0=0; stall0=1 in cycles 0–1, 0 in cycle 2.
- Write with 3 wait cycles: req1=1, we1=1, addr1=0x40, wdata1=0x1234 → mem_we=1, mem_addr=0x40 and mem_wdata=0x1234 stable for 4 cycles; ack1 at cycle 5; rdata unchanged.
- Contention: req0=req1=1 continuously, zero-wait memory → ack order 0,1,0,1, one ack every 3 cycles, never both acks in the same cycle.
- Timeout: TIMEOUT=4, mem_ready held 0 → mem_req high for exactly 4 cycles, then ack0=1, err0=1, rdata=0; a following normal access returns err0=0.
- Reset mid-access: rst pulsed during the second ACCESS cycle → no ack, mem_req=0 after that edge, state IDLE; a subsequent req1 with no req0 is granted normally.
